// File: rtl/lcd_power_sequencer.sv
// rtl/lcd_power_sequencer.sv - LCD pixel PLL power-up, lock qualification, backlight PWM and teardown sequencer
module lcd_power_sequencer #(
  parameter int unsigned PLL_RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned SETTLE_CYCLES    = 4096,
  parameter int unsigned BL_DELAY         = 50000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pll_locked,
  input  logic [7:0] backlight_level,
  input  logic       fault_clear,
  output logic       pll_rst,
  output logic       video_enable,
  output logic       lcd_disp,
  output logic       lcd_backlight,
  output logic [2:0] state,
  output logic       lock_lost
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PLL_RESET = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    VIDEO_ON  = 3'd4,
    RUN       = 3'd5,
    SHUTDOWN  = 3'd6,
    FAULT     = 3'd7
  } state_t;

  localparam logic [19:0] LD_PLL_RESET = 20'(PLL_RESET_CYCLES);
  localparam logic [19:0] LD_LOCK      = 20'(LOCK_TIMEOUT);
  localparam logic [19:0] LD_SETTLE    = 20'(SETTLE_CYCLES);
  localparam logic [19:0] LD_BL        = 20'(BL_DELAY);
  localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRIES);

  state_t      cur;
  state_t      nxt;
  logic [1:0]  lock_sync;
  logic        locked_s;
  logic [19:0] cnt;
  logic [19:0] cnt_load;
  logic        cnt_last;
  logic [2:0]  retries;
  logic [2:0]  retries_inc;
  logic        timeout;
  logic        set_lost;
  logic [7:0]  pwm_cnt;
  logic [7:0]  level_q;
  logic [7:0]  pwm_nxt;
  logic [7:0]  level_nxt;
  logic        pll_rst_d;
  logic        video_d;
  logic        disp_d;
  logic        bl_d;

  assign locked_s    = lock_sync[1];
  assign cnt_last    = (cnt == 20'd1);
  assign retries_inc = retries + 3'd1;
  assign state       = cur;
  // Outputs are computed from the values the PWM registers will hold next,
  // so the registered backlight matches (pwm_cnt < level_q) in the same cycle.
  assign pwm_nxt     = pwm_cnt + 8'd1;
  assign level_nxt   = (pwm_cnt == 8'hFF) ? backlight_level : level_q;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], pll_locked};
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= OFF;
      pll_rst       <= 1'b1;
      video_enable  <= 1'b0;
      lcd_disp      <= 1'b0;
      lcd_backlight <= 1'b0;
    end else begin
      cur           <= nxt;
      pll_rst       <= pll_rst_d;
      video_enable  <= video_d;
      lcd_disp      <= disp_d;
      lcd_backlight <= bl_d;
    end
  end

  // Next-state decision; a low enable outranks any lock event in the same cycle
  always_comb begin
    nxt      = cur;
    timeout  = 1'b0;
    set_lost = 1'b0;
    case (cur)
      OFF:       if (enable) nxt = PLL_RESET;
      PLL_RESET: begin
        if (!enable)       nxt = OFF;
        else if (cnt_last) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!enable)       nxt = OFF;
        else if (locked_s) nxt = SETTLE;
        else if (cnt_last) begin
          timeout = 1'b1;
          nxt     = (retries_inc == RETRY_LIMIT) ? FAULT : PLL_RESET;
        end
      end
      SETTLE: begin
        if (!enable)        nxt = OFF;
        else if (!locked_s) nxt = PLL_RESET;
        else if (cnt_last)  nxt = VIDEO_ON;
      end
      VIDEO_ON, RUN: begin
        if (!enable) nxt = SHUTDOWN;
        else if (!locked_s) begin
          set_lost = 1'b1;
          nxt      = PLL_RESET;
        end else if (cur == VIDEO_ON && cnt_last) nxt = RUN;
      end
      SHUTDOWN: begin
        if (!locked_s) begin
          set_lost = 1'b1;
          nxt      = OFF;
        end else if (cnt_last) nxt = OFF;
      end
      FAULT:     if (fault_clear) nxt = OFF;
      default:   nxt = OFF;
    endcase
  end

  // Output decode for the state being entered
  always_comb begin
    pll_rst_d = 1'b0;
    video_d   = 1'b0;
    disp_d    = 1'b0;
    bl_d      = 1'b0;
    case (nxt)
      OFF, PLL_RESET, FAULT: pll_rst_d = 1'b1;
      VIDEO_ON, SHUTDOWN: begin
        video_d = 1'b1;
        disp_d  = 1'b1;
      end
      RUN: begin
        video_d = 1'b1;
        disp_d  = 1'b1;
        bl_d    = (pwm_nxt < level_nxt);
      end
      default: ;
    endcase
  end

  // Dwell length of the state being entered
  always_comb begin
    cnt_load = 20'd0;
    case (nxt)
      PLL_RESET:          cnt_load = LD_PLL_RESET;
      WAIT_LOCK:          cnt_load = LD_LOCK;
      SETTLE:             cnt_load = LD_SETTLE;
      VIDEO_ON, SHUTDOWN: cnt_load = LD_BL;
      default:            cnt_load = 20'd0;
    endcase
  end

  // Dwell counter: loaded on every state change, exit taken when it reads 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= 20'd0;
    else if (nxt != cur)   cnt <= cnt_load;
    else if (cnt != 20'd0) cnt <= cnt - 20'd1;
  end

  // Lock-timeout retry count, forgotten once lock qualifies or the path returns to OFF
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                retries <= 3'd0;
    else if (nxt == OFF && cur != OFF)        retries <= 3'd0;
    else if (cur == SETTLE && nxt == VIDEO_ON) retries <= 3'd0;
    else if (timeout)                         retries <= retries_inc;
  end

  // Sticky lock-loss flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            lock_lost <= 1'b0;
    else if (set_lost)    lock_lost <= 1'b1;
    else if (fault_clear) lock_lost <= 1'b0;
  end

  // Free-running PWM phase; duty is re-sampled only at the period boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
      level_q <= 8'd0;
    end else begin
      pwm_cnt <= pwm_nxt;
      level_q <= level_nxt;
    end
  end

endmodule
